// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU core's data-memory path: default geometry
// of the 256x16 data memory and the load-store unit FSM encoding.
package gpu_mem_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu.sv
// Load-store unit: takes one request at a time from execute, drives the data
// memory port, waits RD_LAT cycles for load data and returns a response.
//
// Both handshakes follow strict valid/ready: a transfer happens on the rising
// edge where valid and ready are both 1; the sender keeps valid and payload
// stable until then, and ready may not depend on a transfer in that cycle.
module lsu
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_W    = gpu_mem_pkg::ADDR_W,
  parameter int DATA_W    = gpu_mem_pkg::DATA_W,
  parameter int MEM_DEPTH = gpu_mem_pkg::MEM_DEPTH,
  parameter int RD_LAT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT > 0) ? CNT_W'(RD_LAT - 1) : '0;
  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  lsu_state_t        state, state_next;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;
  logic              addr_bad;

  assign addr_bad = ({1'b0, req_addr} >= DEPTH_L);

  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    mem_write  = (state == ISSUE) && wr_q;
    case (state)
      IDLE: begin
        if (req_valid) state_next = addr_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        state_next = (wr_q || RD_LAT == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wd_q    <= req_wdata;
            err_q   <= addr_bad;
            rdata_q <= '0;
          end
        end
        ISSUE: begin
          // Stores leave rdata_q at the zero written on acceptance.
          if (!wr_q) begin
            if (RD_LAT == 0) rdata_q <= mem_rdata;
            else             cnt     <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == '0) rdata_q <= mem_rdata;
          else           cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wd    = wd_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state;

endmodule
